// File: rtl/fix_rx_framer.sv
`default_nettype none
// ============================================================================
// fix_rx_framer : delimits FIX messages in a TOE byte stream ("8=" .. "10=nnn<SOH>")
// Option macro  : FIX_RX_CSUM_CHECK_EN enables the 10= checksum compare.  Rev 1.0
// ============================================================================
module fix_rx_framer #(
    parameter logic [7:0] SOH     = 8'h01,
    parameter int         MAX_LEN = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_i,
    input  logic       byte_valid_i,
    output logic       byte_ready_o,
    output logic [7:0] msg_byte_o,
    output logic       msg_valid_o,
    input  logic       msg_ready_i,
    output logic       msg_sop_o,
    output logic       msg_eop_o,
    output logic       msg_err_o
);

    localparam int                LEN_W     = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0]  c_MAX_LEN = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]  c_ONE     = LEN_W'(1);

    localparam logic [2:0] c_HUNT = 3'd0;
    localparam logic [2:0] c_HDR  = 3'd1;
    localparam logic [2:0] c_BODY = 3'd2;
    localparam logic [2:0] c_CSUM = 3'd3;
    localparam logic [2:0] c_TERM = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [1:0]       pos_q, pos_d;
    logic             tag_q, tag_d;
    logic [1:0]       dig_q, dig_d;
    logic [7:0]       msg_byte_q, msg_byte_d;
    logic             msg_valid_q, msg_valid_d;
    logic             msg_sop_q, msg_sop_d;
    logic             msg_eop_q, msg_eop_d;
    logic             msg_err_q, msg_err_d;
`ifdef FIX_RX_CSUM_CHECK_EN
    logic [9:0]       val_q, val_d;
    logic [7:0]       sum_q, sum_d;
    logic [7:0]       snap_q, snap_d;
`endif

    logic             w_accept;
    logic             w_is_digit;
    logic             w_csum_bad;
    logic [LEN_W-1:0] w_len_inc;
    logic             w_fwd, w_sop, w_eop, w_err;

    assign byte_ready_o = rst & (~msg_valid_q | msg_ready_i);
    assign w_accept     = byte_valid_i & byte_ready_o;
    assign w_is_digit   = (byte_i >= 8'h30) && (byte_i <= 8'h39);
    assign w_len_inc    = len_q + c_ONE;
`ifdef FIX_RX_CSUM_CHECK_EN
    // Values 256..999 can never equal an 8-bit snapshot, so they mismatch naturally.
    assign w_csum_bad   = (val_q != {2'b00, snap_q});
`else
    assign w_csum_bad   = 1'b0;
`endif

    assign msg_byte_o  = msg_byte_q;
    assign msg_valid_o = msg_valid_q;
    assign msg_sop_o   = msg_sop_q;
    assign msg_eop_o   = msg_eop_q;
    assign msg_err_o   = msg_err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= c_HUNT;
            len_q       <= '0;
            pos_q       <= 2'd0;
            tag_q       <= 1'b0;
            dig_q       <= 2'd0;
            msg_byte_q  <= 8'h00;
            msg_valid_q <= 1'b0;
            msg_sop_q   <= 1'b0;
            msg_eop_q   <= 1'b0;
            msg_err_q   <= 1'b0;
`ifdef FIX_RX_CSUM_CHECK_EN
            val_q       <= 10'd0;
            sum_q       <= 8'h00;
            snap_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            pos_q       <= pos_d;
            tag_q       <= tag_d;
            dig_q       <= dig_d;
            msg_byte_q  <= msg_byte_d;
            msg_valid_q <= msg_valid_d;
            msg_sop_q   <= msg_sop_d;
            msg_eop_q   <= msg_eop_d;
            msg_err_q   <= msg_err_d;
`ifdef FIX_RX_CSUM_CHECK_EN
            val_q       <= val_d;
            sum_q       <= sum_d;
            snap_q      <= snap_d;
`endif
        end
    end

    // Per-byte decision: forward or drop, and the sop/eop/err tags it carries.
    always_comb begin
        w_fwd = 1'b0;
        w_sop = 1'b0;
        w_eop = 1'b0;
        w_err = 1'b0;
        case (state_q)
            c_HUNT: begin
                if (byte_i == 8'h38) begin
                    w_fwd = 1'b1;
                    w_sop = 1'b1;
                end
            end
            c_HDR: begin
                w_fwd = 1'b1;
                if (byte_i != 8'h3D) begin
                    w_eop = 1'b1;
                    w_err = 1'b1;
                end
            end
            c_BODY: w_fwd = 1'b1;
            c_CSUM: begin
                w_fwd = 1'b1;
                if (!w_is_digit) begin
                    w_eop = 1'b1;
                    w_err = 1'b1;
                end
            end
            c_TERM: begin
                w_fwd = 1'b1;
                w_eop = 1'b1;
                w_err = (byte_i != SOH) | w_csum_bad;
            end
            default: ;
        endcase
        if (w_fwd && !w_sop && !w_eop && (w_len_inc == c_MAX_LEN)) begin
            w_eop = 1'b1;
            w_err = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        pos_d       = pos_q;
        tag_d       = tag_q;
        dig_d       = dig_q;
        msg_byte_d  = msg_byte_q;
        msg_valid_d = msg_valid_q;
        msg_sop_d   = msg_sop_q;
        msg_eop_d   = msg_eop_q;
        msg_err_d   = msg_err_q;
`ifdef FIX_RX_CSUM_CHECK_EN
        val_d       = val_q;
        sum_d       = sum_q;
        snap_d      = snap_q;
`endif
        if (w_accept) begin
            msg_valid_d = w_fwd;
            if (w_fwd) begin
                msg_byte_d = byte_i;
                msg_sop_d  = w_sop;
                msg_eop_d  = w_eop;
                msg_err_d  = w_err;
            end
        end else if (msg_ready_i) begin
            msg_valid_d = 1'b0;
        end

        if (w_accept && w_fwd) begin
            len_d = w_sop ? c_ONE : w_len_inc;
`ifdef FIX_RX_CSUM_CHECK_EN
            sum_d = w_sop ? byte_i : (sum_q + byte_i);
`endif
            if (w_eop) begin
                state_d = c_HUNT;
            end else begin
                case (state_q)
                    c_HUNT: state_d = c_HDR;
                    c_HDR: begin
                        // Body starts at offset 2 of the "8=" field.
                        state_d = c_BODY;
                        pos_d   = 2'd2;
                        tag_d   = 1'b0;
                    end
                    c_BODY: begin
                        if (byte_i == SOH) begin
                            pos_d = 2'd0;
                            tag_d = 1'b0;
`ifdef FIX_RX_CSUM_CHECK_EN
                            snap_d = sum_q + byte_i;
`endif
                        end else begin
                            case (pos_q)
                                2'd0: begin
                                    tag_d = (byte_i == 8'h31);
                                    pos_d = 2'd1;
                                end
                                2'd1: begin
                                    tag_d = tag_q && (byte_i == 8'h30);
                                    pos_d = 2'd2;
                                end
                                2'd2: begin
                                    pos_d = 2'd3;
                                    if (tag_q && (byte_i == 8'h3D)) begin
                                        state_d = c_CSUM;
                                        dig_d   = 2'd0;
`ifdef FIX_RX_CSUM_CHECK_EN
                                        val_d   = 10'd0;
`endif
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    c_CSUM: begin
                        dig_d = dig_q + 2'd1;
`ifdef FIX_RX_CSUM_CHECK_EN
                        val_d = (val_q * 10'd10) + {6'd0, byte_i[3:0]};
`endif
                        if (dig_q == 2'd2) begin
                            state_d = c_TERM;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
